alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_pkg.sv | 21 ++
 rtl/wb_fifo2.sv | 43 ++++
 rtl/alu_writeback.sv | 81 ++++++++
 tb/tb_alu_writeback.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared flag layout and defaults for the ALU writeback stage
package alu_pkg;

    localparam int WIDTH_DEFAULT = 20;

    localparam int ZERO  = 0;
    localparam int CARRY = 1;
    localparam int SIGN  = 2;

    typedef logic [2:0] alu_flags_t;

    // Bits selected by the mask take the new value, the rest keep the old one.
    function automatic alu_flags_t merge_flags(
        input alu_flags_t old_flags,
        input alu_flags_t new_flags,
        input alu_flags_t we
    );
        return (old_flags & ~we) | (new_flags & we);
    endfunction

endpackage

// File: rtl/wb_fifo2.sv
// rtl/wb_fifo2.sv - two-entry FIFO holding pending register-file writebacks
module wb_fifo2 #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) r_wr_ptr <= ~r_wr_ptr;
            if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is left uncleared by reset; count gates its visibility.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result writeback queue with status flags and writeback counter
module alu_writeback
    import alu_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_result,
    input  logic              in_zero,
    input  logic              in_carry,
    input  logic              in_sign,
    input  alu_flags_t        in_flag_we,
    input  logic              in_wb_en,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [DEST_W-1:0] out_dest,
    output alu_flags_t        flags_q,
    output logic [15:0]       wb_count,
    output logic              busy
);

    localparam int EW = WIDTH + DEST_W;

    logic [1:0]    w_count;
    logic [EW-1:0] w_head;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    alu_flags_t    w_new_flags;
    alu_flags_t    r_flags;
    logic [15:0]   r_wb_count;

    // Ready is held low while reset is asserted so nothing is taken mid-reset.
    assign in_ready  = rst_n & (w_count != 2'd2);
    assign out_valid = (w_count != 2'd0);
    assign busy      = out_valid;

    assign w_accept = in_valid & in_ready;
    assign w_push   = w_accept & in_wb_en;
    assign w_pop    = out_valid & out_ready;

    always_comb begin
        w_new_flags        = '0;
        w_new_flags[ZERO]  = in_zero;
        w_new_flags[CARRY] = in_carry;
        w_new_flags[SIGN]  = in_sign;
    end

    wb_fifo2 #(.W(EW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({in_result, in_dest}),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign out_data = w_head[EW-1:DEST_W];
    assign out_dest = w_head[DEST_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags    <= '0;
            r_wb_count <= '0;
        end else begin
            if (w_accept) r_flags <= merge_flags(r_flags, w_new_flags, in_flag_we);
            if (w_pop && (r_wb_count != 16'hFFFF)) r_wb_count <= r_wb_count + 16'd1;
        end
    end

    assign flags_q  = r_flags;
    assign wb_count = r_wb_count;

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - directed vector bench for alu_writeback
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_result = '0;
    logic        in_zero = 1'b0;
    logic        in_carry = 1'b0;
    logic        in_sign = 1'b0;
    logic [2:0]  in_flag_we = '0;
    logic        in_wb_en = 1'b0;
    logic [3:0]  in_dest = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] out_data;
    logic [3:0]  out_dest;
    logic [2:0]  flags_q;
    logic [15:0] wb_count;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    alu_writeback #(.WIDTH(20), .DEST_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_zero    (in_zero),
        .in_carry   (in_carry),
        .in_sign    (in_sign),
        .in_flag_we (in_flag_we),
        .in_wb_en   (in_wb_en),
        .in_dest    (in_dest),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_dest   (out_dest),
        .flags_q    (flags_q),
        .wb_count   (wb_count),
        .busy       (busy)
    );

    typedef struct {
        logic        v;
        logic [19:0] res;
        logic [2:0]  fl;      // {sign,carry,zero}
        logic [2:0]  we;
        logic        wben;
        logic [3:0]  dest;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [19:0] e_data;
        logic [3:0]  e_dest;
        logic [2:0]  e_flags;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(
        input logic v, input logic [19:0] res, input logic [2:0] fl, input logic [2:0] we,
        input logic wben, input logic [3:0] dest, input logic ordy,
        input logic e_rdy, input logic e_ov, input logic [19:0] e_data, input logic [3:0] e_dest,
        input logic [2:0] e_flags, input logic [15:0] e_cnt
    );
        vec_t t;
        t.v = v; t.res = res; t.fl = fl; t.we = we; t.wben = wben; t.dest = dest; t.ordy = ordy;
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_data = e_data; t.e_dest = e_dest;
        t.e_flags = e_flags; t.e_cnt = e_cnt;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic drive(input logic v, input logic [19:0] res, input logic [2:0] fl,
                         input logic [2:0] we, input logic wben, input logic [3:0] dest,
                         input logic ordy);
        in_valid = v; in_result = res; in_sign = fl[2]; in_carry = fl[1]; in_zero = fl[0];
        in_flag_we = we; in_wb_en = wben; in_dest = dest; out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            v  res       fl     we     wb dst ordy | rdy ov data      dst flags  cnt
        vecs[0]  = mk(1, 20'h00001, 3'b000, 3'b000, 1, 3, 1,   1,  1, 20'h00001, 3, 3'b000, 0);
        vecs[1]  = mk(0, 20'h00000, 3'b000, 3'b000, 0, 0, 1,   1,  0, 20'h00000, 0, 3'b000, 1);
        vecs[2]  = mk(1, 20'hAAAAA, 3'b000, 3'b000, 1, 5, 0,   1,  1, 20'hAAAAA, 5, 3'b000, 1);
        vecs[3]  = mk(1, 20'h55555, 3'b000, 3'b000, 1, 6, 0,   0,  1, 20'hAAAAA, 5, 3'b000, 1);
        vecs[4]  = mk(1, 20'h12345, 3'b111, 3'b111, 1, 7, 0,   0,  1, 20'hAAAAA, 5, 3'b000, 1);
        vecs[5]  = mk(0, 20'h00000, 3'b000, 3'b000, 0, 0, 1,   1,  1, 20'h55555, 6, 3'b000, 2);
        vecs[6]  = mk(0, 20'h00000, 3'b000, 3'b000, 0, 0, 1,   1,  0, 20'h00000, 0, 3'b000, 3);
        vecs[7]  = mk(1, 20'h00000, 3'b001, 3'b001, 0, 0, 0,   1,  0, 20'h00000, 0, 3'b001, 3);
        vecs[8]  = mk(1, 20'h00000, 3'b010, 3'b110, 0, 0, 0,   1,  0, 20'h00000, 0, 3'b011, 3);
        vecs[9]  = mk(1, 20'h00000, 3'b100, 3'b111, 0, 0, 0,   1,  0, 20'h00000, 0, 3'b100, 3);
        vecs[10] = mk(1, 20'h00011, 3'b000, 3'b000, 1, 1, 0,   1,  1, 20'h00011, 1, 3'b100, 3);
        vecs[11] = mk(1, 20'h00022, 3'b000, 3'b000, 1, 2, 1,   1,  1, 20'h00022, 2, 3'b100, 4);
        vecs[12] = mk(1, 20'h00033, 3'b000, 3'b000, 1, 3, 0,   0,  1, 20'h00022, 2, 3'b100, 4);
        vecs[13] = mk(1, 20'h00044, 3'b000, 3'b000, 1, 4, 1,   1,  1, 20'h00033, 3, 3'b100, 5);
        vecs[14] = mk(1, 20'h00044, 3'b000, 3'b000, 1, 4, 0,   0,  1, 20'h00033, 3, 3'b100, 5);
        vecs[15] = mk(0, 20'h00000, 3'b000, 3'b000, 0, 0, 1,   1,  1, 20'h00044, 4, 3'b100, 6);
        vecs[16] = mk(0, 20'h00000, 3'b000, 3'b000, 0, 0, 1,   1,  0, 20'h00000, 0, 3'b100, 7);

        // Reset asserted with no clock edge yet seen.
        #1 rst_n = 1'b0;
        #1;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.in_ready",  {31'd0, in_ready},  32'd0);
        check("rst.busy",      {31'd0, busy},      32'd0);
        check("rst.flags_q",   {29'd0, flags_q},   32'd0);
        check("rst.wb_count",  {16'd0, wb_count}, 32'd0);
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].v, vecs[i].res, vecs[i].fl, vecs[i].we, vecs[i].wben, vecs[i].dest, vecs[i].ordy);
            step();
            check($sformatf("v%0d.in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_rdy});
            check($sformatf("v%0d.out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            check($sformatf("v%0d.busy", i),      {31'd0, busy},      {31'd0, vecs[i].e_ov});
            check($sformatf("v%0d.flags_q", i),   {29'd0, flags_q},   {29'd0, vecs[i].e_flags});
            check($sformatf("v%0d.wb_count", i),  {16'd0, wb_count},  {16'd0, vecs[i].e_cnt});
            if (vecs[i].e_ov) begin
                check($sformatf("v%0d.out_data", i), {12'd0, out_data}, {12'd0, vecs[i].e_data});
                check($sformatf("v%0d.out_dest", i), {28'd0, out_dest}, {28'd0, vecs[i].e_dest});
            end
        end

        // Saturation: reset, then stream push+pop so every cycle after the first pops once.
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("sat.wb_count_reset", {16'd0, wb_count}, 32'd0);
        for (int i = 0; i < 65535; i++) begin
            drive(1, 20'(i), 0, 0, 1, 4'(i), 1);
            step();
        end
        check("sat.wb_count_fffe", {16'd0, wb_count}, 32'h0000FFFE);
        check("sat.out_data", {12'd0, out_data}, 32'd65534);
        for (int i = 0; i < 3; i++) begin
            drive(1, 20'(i), 0, 0, 1, 4'(i), 1);
            step();
        end
        check("sat.wb_count_ffff", {16'd0, wb_count}, 32'h0000FFFF);

        // Asynchronous reset with a full queue and all flags set.
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        step();
        drive(1, 20'h0000A, 3'b111, 3'b111, 1, 1, 0);
        step();
        drive(1, 20'h0000B, 3'b000, 3'b000, 1, 2, 0);
        step();
        check("ar.pre_in_ready", {31'd0, in_ready}, 32'd0);
        check("ar.pre_flags",    {29'd0, flags_q},  32'd7);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("ar.out_valid", {31'd0, out_valid}, 32'd0);
        check("ar.in_ready",  {31'd0, in_ready},  32'd0);
        check("ar.flags_q",   {29'd0, flags_q},   32'd0);
        check("ar.wb_count",  {16'd0, wb_count},  32'd0);
        step();
        rst_n = 1'b1;
        drive(1, 20'hABCDE, 3'b000, 3'b000, 1, 9, 0);
        step();
        check("ar.first_ov",   {31'd0, out_valid}, 32'd1);
        check("ar.first_data", {12'd0, out_data},  32'h000ABCDE);
        check("ar.first_dest", {28'd0, out_dest},  32'd9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
